// File: rtl/subleq_hs.sv
// Subleq OISC core: mem[B] := mem[B] - mem[A], branch to C when the result is <= 0.
// Single unified memory reached through a registered request/acknowledge handshake.
module subleq_hs #(
  parameter int BITS        = 16,
  parameter int COUNT_BITS  = 32,
  parameter bit HALT_ON_NEG = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BITS-1:0]       mem_addr,
  output logic [BITS-1:0]       mem_wdata,
  input  logic [BITS-1:0]       mem_rdata,
  input  logic                  mem_ack,
  output logic                  halt,
  output logic                  busy,
  output logic [BITS-1:0]       pc,
  output logic [COUNT_BITS-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_PAUSED,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_LOAD_A,
    S_LOAD_B,
    S_STORE,
    S_HALTED
  } state_t;

  localparam logic signed [BITS-1:0] ZERO = '0;

  state_t                r_state, w_state_nxt;
  logic [BITS-1:0]       r_pc, r_ra, r_rb, r_rc, r_va, r_vb;
  logic [BITS-1:0]       w_pc_nxt, w_ra_nxt, w_rb_nxt, w_rc_nxt, w_va_nxt, w_vb_nxt;
  logic [COUNT_BITS-1:0] r_count, w_count_nxt;
  logic                  r_req, r_we;
  logic [BITS-1:0]       r_addr, r_wdata;
  logic                  w_req_nxt, w_we_nxt;
  logic [BITS-1:0]       w_addr_nxt, w_wdata_nxt;
  logic                  w_ack, w_taken, w_halt_cond;
  logic signed [BITS-1:0] w_res;

  // While in STORE the write-data register already holds vb - va.
  assign w_ack       = r_req & mem_ack;
  assign w_res       = $signed(r_wdata);
  assign w_taken     = (w_res <= ZERO);
  assign w_halt_cond = w_taken && ((r_rc == r_pc) || (HALT_ON_NEG && r_rc[BITS-1]));

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ra_nxt    = r_ra;
    w_rb_nxt    = r_rb;
    w_rc_nxt    = r_rc;
    w_va_nxt    = r_va;
    w_vb_nxt    = r_vb;
    w_count_nxt = r_count;
    case (r_state)
      S_PAUSED:  if (run) w_state_nxt = S_FETCH_A;
      S_FETCH_A: if (w_ack) begin w_ra_nxt = mem_rdata; w_state_nxt = S_FETCH_B; end
      S_FETCH_B: if (w_ack) begin w_rb_nxt = mem_rdata; w_state_nxt = S_FETCH_C; end
      S_FETCH_C: if (w_ack) begin w_rc_nxt = mem_rdata; w_state_nxt = S_LOAD_A;  end
      S_LOAD_A:  if (w_ack) begin w_va_nxt = mem_rdata; w_state_nxt = S_LOAD_B;  end
      S_LOAD_B:  if (w_ack) begin w_vb_nxt = mem_rdata; w_state_nxt = S_STORE;   end
      S_STORE: begin
        if (w_ack) begin
          w_count_nxt = r_count + COUNT_BITS'(1);
          w_pc_nxt    = w_taken ? r_rc : r_pc + BITS'(3);
          if (w_halt_cond)
            w_state_nxt = S_HALTED;
          else if (run)
            w_state_nxt = S_FETCH_A;
          else
            w_state_nxt = S_PAUSED;
        end
      end
      S_HALTED:  w_state_nxt = S_HALTED;
      default:   w_state_nxt = S_PAUSED;
    endcase

    // The request for the state being entered is registered on the same edge,
    // so it is stable from the first request cycle through the ack cycle.
    w_req_nxt   = 1'b1;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = '0;
    w_wdata_nxt = '0;
    case (w_state_nxt)
      S_FETCH_A: w_addr_nxt = w_pc_nxt;
      S_FETCH_B: w_addr_nxt = w_pc_nxt + BITS'(1);
      S_FETCH_C: w_addr_nxt = w_pc_nxt + BITS'(2);
      S_LOAD_A:  w_addr_nxt = w_ra_nxt;
      S_LOAD_B:  w_addr_nxt = w_rb_nxt;
      S_STORE: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = w_rb_nxt;
        w_wdata_nxt = w_vb_nxt - w_va_nxt;
      end
      default:   w_req_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_PAUSED;
      r_pc    <= '0;
      r_count <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Operand registers carry no reset; they are always loaded before use.
  always_ff @(posedge clock) begin
    r_ra <= w_ra_nxt;
    r_rb <= w_rb_nxt;
    r_rc <= w_rc_nxt;
    r_va <= w_va_nxt;
    r_vb <= w_vb_nxt;
  end

  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign halt        = (r_state == S_HALTED);
  assign busy        = (r_state != S_PAUSED) && (r_state != S_HALTED);
  assign pc          = r_pc;
  assign instr_count = r_count;

endmodule

// File: tb/tb_subleq_hs.sv
// Bench for subleq_hs: an interpreter predicts every bus transfer into a queue,
// a monitor pops and compares each acknowledged transfer.
module tb_subleq_hs;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  pc;
    int unsigned cnt;
    bit          halt;
  } xfer_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic        mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;
  logic        halt, busy;
  logic [7:0]  pc;
  logic [31:0] instr_count;

  logic        reset0 = 1'b1;
  logic        run0   = 1'b0;
  logic        req0, we0, halt0, busy0;
  logic [7:0]  addr0, wdata0, rdata0, pc0;
  logic [31:0] cnt0;

  logic [7:0]  mem  [256];
  logic [7:0]  mem0 [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_pc;
  int unsigned ref_cnt;
  bit          ref_halt;

  xfer_t      exp_q[$];
  logic [7:0] addr_log[$];
  logic [7:0] log0[$];
  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int lat_mode = 0;
  int wait_cnt = 0;
  int cur_lat = 0;

  always #5 clock = ~clock;

  subleq_hs #(.BITS(8), .COUNT_BITS(32), .HALT_ON_NEG(1'b1)) u_dut (
    .clock(clock), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halt(halt), .busy(busy), .pc(pc), .instr_count(instr_count)
  );

  subleq_hs #(.BITS(8), .COUNT_BITS(32), .HALT_ON_NEG(1'b0)) u_dut0 (
    .clock(clock), .reset(reset0), .run(run0),
    .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .mem_rdata(rdata0), .mem_ack(1'b1),
    .halt(halt0), .busy(busy0), .pc(pc0), .instr_count(cnt0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Memory responder with selectable wait states (lat_mode < 0: random 0..3).
  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (reset || !mem_req) begin
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      if (wait_cnt >= cur_lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem[mem_addr];
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Zero-wait memory for the second core (ack tied high).
  assign rdata0 = mem0[addr0];
  always @(negedge clock) begin
    if (!reset0 && req0 && we0) mem0[addr0] = wdata0;
    #1;
    if (!reset0 && req0) log0.push_back(addr0);
  end

  // Monitor: request stability, scoreboard compare, architectural state after each store.
  bit         prev_wait = 1'b0;
  bit         post_pend = 1'b0;
  logic       prev_we;
  logic [7:0] prev_addr, prev_wdata;
  xfer_t      post_x;
  xfer_t      cur_x;

  always @(negedge clock) begin
    #1;
    if (reset) begin
      prev_wait = 1'b0;
      post_pend = 1'b0;
    end else begin
      if (post_pend) begin
        check("post_pc", pc, post_x.pc);
        check("post_count", instr_count, post_x.cnt);
        check("post_halt", halt, post_x.halt);
        post_pend = 1'b0;
      end
      if (halt) check("halted_no_req", mem_req, 0);
      if (prev_wait) begin
        check("hold_req", mem_req, 1);
        check("hold_we", mem_we, prev_we);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      prev_wait = 1'b0;
      if (mem_req) begin
        req_cycles++;
        check("busy_in_xfer", busy, 1);
        if (mem_ack) begin
          addr_log.push_back(mem_addr);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got addr %0d we %0d, required no transfer", mem_addr, mem_we);
          end else begin
            cur_x = exp_q.pop_front();
            check("xfer_we", mem_we, cur_x.we);
            check("xfer_addr", mem_addr, cur_x.addr);
            if (cur_x.we) begin
              check("xfer_wdata", mem_wdata, cur_x.wdata);
              post_x    = cur_x;
              post_pend = 1'b1;
            end
          end
        end else begin
          prev_wait  = 1'b1;
          prev_we    = mem_we;
          prev_addr  = mem_addr;
          prev_wdata = mem_wdata;
        end
      end
    end
  end

  task automatic push_x(input bit we, input logic [7:0] addr, input logic [7:0] wdata);
    xfer_t x;
    x.we = we; x.addr = addr; x.wdata = wdata;
    x.pc = ref_pc; x.cnt = ref_cnt; x.halt = ref_halt;
    exp_q.push_back(x);
  endtask

  // Reference interpreter: plain subleq on a copy of memory (HALT_ON_NEG=1).
  task automatic ref_generate(input int n);
    logic [7:0] old, p1, p2, a, b, c, res;
    bit taken;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int k = 0; k < n && !ref_halt; k++) begin
      old = ref_pc;
      p1  = old + 8'd1;
      p2  = old + 8'd2;
      a   = ref_mem[old];
      b   = ref_mem[p1];
      c   = ref_mem[p2];
      res = ref_mem[b] - ref_mem[a];
      push_x(0, old, 0); push_x(0, p1, 0); push_x(0, p2, 0);
      push_x(0, a, 0);   push_x(0, b, 0);
      ref_mem[b] = res;
      taken    = ($signed(res) <= 8'sd0);
      ref_pc   = taken ? c : old + 8'd3;
      ref_halt = taken && (c == old || c[7]);
      ref_cnt++;
      push_x(1, b, res);
    end
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    reset = 1'b1; run = 1'b0;
    exp_q.delete();
    ref_pc = 8'd0; ref_cnt = 0; ref_halt = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[0] = 8'd9; mem[1] = 8'd10; mem[2] = 8'd6;
    mem[9] = 8'd5; mem[10] = 8'd7;
  endtask

  task automatic wait_q(input int n, input string name);
    int t = 0;
    while (exp_q.size() > n && t < 500) begin
      @(negedge clock); #2;
      t++;
    end
    check(name, t < 500, 1);
  endtask

  task automatic run_to_end();
    int t = 0;
    int bad = 0;
    run = 1'b1;
    while (t < 3000) begin
      @(negedge clock); #2;
      if (exp_q.size() <= 5) run = 1'b0;
      if (exp_q.size() == 0 && !busy) break;
      t++;
    end
    check("run_timeout", t < 3000, 1);
    check("end_pc", pc, ref_pc);
    check("end_count", instr_count, ref_cnt);
    check("end_halt", halt, ref_halt);
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image_diffs", bad, 0);
  endtask

  task automatic reset0_pulse();
    @(negedge clock); #2;
    reset0 = 1'b1; run0 = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset0 = 1'b0;
    log0.delete();
    for (int i = 0; i < 256; i++) mem0[i] = 8'd0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_addrs [6];
    exp_addrs[0] = 8'd0; exp_addrs[1] = 8'd1; exp_addrs[2] = 8'd2;
    exp_addrs[3] = 8'd9; exp_addrs[4] = 8'd10; exp_addrs[5] = 8'd10;

    do_reset();
    check("rst_pc", pc, 0);
    check("rst_count", instr_count, 0);
    check("rst_halt", halt, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);

    // Not-taken instruction, zero wait states
    do_reset(); load_prog1(); lat_mode = 0;
    req_cycles = 0; addr_log.delete();
    ref_generate(1); run_to_end();
    check("s1_mem10", mem[10], 2);
    check("s1_pc", pc, 3);
    check("s1_count", instr_count, 1);
    check("s1_req_cycles", req_cycles, 6);
    check("s1_addr_count", addr_log.size(), 6);
    for (int i = 0; i < 6; i++) check("s1_addr_seq", addr_log[i], exp_addrs[i]);

    // Taken branch, then self-loop halt
    do_reset(); load_prog1();
    mem[9] = 8'd7; mem[10] = 8'd5;
    mem[6] = 8'd11; mem[7] = 8'd11; mem[8] = 8'd6; mem[11] = 8'd3;
    ref_generate(5); run_to_end();
    check("s2_mem10", mem[10], 8'hFE);
    check("s2_mem11", mem[11], 0);
    check("s2_halt", halt, 1);
    check("s2_count", instr_count, 2);
    run = 1'b1;
    repeat (10) @(negedge clock);
    #2;
    check("s2_busy_after_halt", busy, 0);
    check("s2_halt_sticky", halt, 1);
    run = 1'b0;

    // Four-cycle wait states
    do_reset(); load_prog1(); lat_mode = 3;
    req_cycles = 0;
    ref_generate(1); run_to_end();
    check("s3_req_cycles", req_cycles, 24);
    check("s3_mem10", mem[10], 2);

    // Pause during LOAD_A, then resume
    do_reset(); load_prog1(); lat_mode = 0;
    mem[3] = 8'd12; mem[4] = 8'd13; mem[5] = 8'd0; mem[12] = 8'd1; mem[13] = 8'd9;
    ref_generate(2);
    run = 1'b1;
    wait_q(8, "pause_reach_load_a");
    run = 1'b0;
    wait_q(6, "pause_reach_store");
    @(negedge clock); #2;
    check("pause_busy", busy, 0);
    check("pause_req", mem_req, 0);
    check("pause_pc", pc, 3);
    check("pause_count", instr_count, 1);
    repeat (5) begin
      @(negedge clock); #2;
      check("pause_no_req", mem_req, 0);
    end
    run = 1'b1;
    @(negedge clock); #2;
    check("resume_req", mem_req, 1);
    check("resume_addr", mem_addr, 3);
    check("resume_we", mem_we, 0);
    run_to_end();

    // Reset while STORE is waiting for ack
    do_reset(); load_prog1(); lat_mode = 3;
    ref_generate(1);
    run = 1'b1;
    begin
      int t = 0;
      while (!(mem_req && mem_we) && t < 200) begin
        @(negedge clock); #2;
        t++;
      end
      check("store_wait_reached", t < 200, 1);
    end
    reset = 1'b1; run = 1'b0; exp_q.delete();
    @(negedge clock); #2;
    check("midrst_req", mem_req, 0);
    check("midrst_pc", pc, 0);
    check("midrst_count", instr_count, 0);
    check("midrst_halt", halt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mem10", mem[10], 7);
    reset = 1'b0;

    // Taken branch to an address with MSB set halts this core
    do_reset(); clear_mem(); lat_mode = 0;
    mem[0] = 8'd20; mem[1] = 8'd21; mem[2] = 8'h80; mem[20] = 8'd1; mem[21] = 8'd1;
    ref_generate(3); run_to_end();
    check("neg_halt", halt, 1);
    check("neg_pc", pc, 8'h80);
    check("neg_mem21", mem[21], 0);

    // Random programs with random wait states
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      lat_mode = -1;
      ref_generate(25);
      run_to_end();
    end

    // HALT_ON_NEG=0 core: wrap of fetch addresses at 253..255
    reset0_pulse();
    mem0[0] = 8'd20; mem0[1] = 8'd21; mem0[2] = 8'd253; mem0[20] = 8'd1; mem0[21] = 8'd1;
    mem0[253] = 8'd22; mem0[254] = 8'd23; mem0[255] = 8'h40; mem0[22] = 8'd1; mem0[23] = 8'd5;
    run0 = 1'b1;
    repeat (7) @(negedge clock);
    #2;
    check("wrap_pc253", pc0, 253);
    check("wrap_count1", cnt0, 1);
    repeat (6) @(negedge clock);
    #2;
    check("wrap_pc0", pc0, 0);
    check("wrap_count2", cnt0, 2);
    check("wrap_mem23", mem0[23], 4);
    check("wrap_halt", halt0, 0);
    check("wrap_fetch0", log0[6], 253);
    check("wrap_fetch1", log0[7], 254);
    check("wrap_fetch2", log0[8], 255);
    run0 = 1'b0;

    // HALT_ON_NEG=0 core: branch to 0x80 keeps running
    reset0_pulse();
    mem0[0] = 8'd20; mem0[1] = 8'd21; mem0[2] = 8'h80; mem0[20] = 8'd1; mem0[21] = 8'd1;
    mem0[8'h80] = 8'd22; mem0[8'h81] = 8'd23; mem0[8'h82] = 8'd0; mem0[22] = 8'd1; mem0[23] = 8'd5;
    run0 = 1'b1;
    repeat (7) @(negedge clock);
    #2;
    check("noneg_pc80", pc0, 8'h80);
    check("noneg_halt1", halt0, 0);
    repeat (6) @(negedge clock);
    #2;
    check("noneg_pc83", pc0, 8'h83);
    check("noneg_halt2", halt0, 0);
    check("noneg_count", cnt0, 2);
    run0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
